// File: rtl/regfile_write_buffer.sv
// ---------------------------------------------------------------------------
// regfile_write_buffer
//
// Write-side staging FIFO placed directly in front of the dual-write-port
// register file. It accepts one write request per cycle and drains up to two
// per cycle. The older entry always goes on port 1 and the newer one on
// port 2. The register file gives port 2 priority on an address collision,
// so a same-address pair still resolves in program order.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   in_valid   write request present
//   in_ready   buffer accepts a request this cycle (registered occupancy only)
//   in_addr    destination register of the request
//   in_data    data of the request
//   drain_en   consumer commits we[] at this edge (its ce && en)
//   waddress1  address of the oldest entry
//   wdata1     data of the oldest entry
//   waddress2  address of the second-oldest entry
//   wdata2     data of the second-oldest entry
//   we         per-port write enables {port2, port1}
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
// ---------------------------------------------------------------------------
module regfile_write_buffer #(
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  drain_en,
    output logic [ADDR_WIDTH-1:0] waddress1,
    output logic [WIDTH-1:0]      wdata1,
    output logic [ADDR_WIDTH-1:0] waddress2,
    output logic [WIDTH-1:0]      wdata2,
    output logic [1:0]            we,
    output logic [PTR_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] ONE_CNT   = (PTR_WIDTH+1)'(1);

    // Number of entries retired at this edge: one per asserted write enable.
    function automatic logic [1:0] pop_count(input logic [1:0] w);
        return {1'b0, w[0]} + {1'b0, w[1]};
    endfunction

    // Entry storage. Contents are data only and are never cleared.
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [WIDTH-1:0]      data_mem [DEPTH];

    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH:0]   count_q;

    logic [PTR_WIDTH-1:0] rd_ptr_next;
    logic                 push;
    logic [1:0]           pops;

    assign count = count_q;
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // Acceptance depends on registered occupancy only. A drain in the same
    // cycle does not open a slot until the following cycle. Reset low
    // forces the buffer to refuse requests.
    assign in_ready = reset && !full;
    assign push     = in_valid && in_ready;

    // The second entry sits one slot past the head, with natural wrap.
    assign rd_ptr_next = rd_ptr + PTR_WIDTH'(1);

    assign waddress1 = addr_mem[rd_ptr];
    assign wdata1    = data_mem[rd_ptr];
    assign waddress2 = addr_mem[rd_ptr_next];
    assign wdata2    = data_mem[rd_ptr_next];

    // Port 1 needs at least one entry and port 2 needs at least two. Both
    // are forced off while reset is low.
    assign we[0] = reset && drain_en && (count_q != '0);
    assign we[1] = reset && drain_en && (count_q > ONE_CNT);

    assign pops = pop_count(we);

    // Control state: pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            rd_ptr  <= rd_ptr + PTR_WIDTH'(pops);
            count_q <= count_q + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pops);
        end
    end

    // Data state: entry written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

    localparam int DEPTH      = 8;
    localparam int PTR_WIDTH  = 3;
    localparam int ADDR_WIDTH = 5;
    localparam int WIDTH      = 8;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [WIDTH-1:0]      in_data;
    logic                  drain_en;
    logic [ADDR_WIDTH-1:0] waddress1;
    logic [WIDTH-1:0]      wdata1;
    logic [ADDR_WIDTH-1:0] waddress2;
    logic [WIDTH-1:0]      wdata2;
    logic [1:0]            we;
    logic [PTR_WIDTH:0]    count;
    logic                  full;
    logic                  empty;

    int errors = 0;
    int checks = 0;

    regfile_write_buffer #(
        .DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
        .waddress1(waddress1), .wdata1(wdata1), .waddress2(waddress2), .wdata2(wdata2),
        .we(we), .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled around the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held for two edges with a request offered
        reset    = 1'b0;
        in_valid = 1'b1;
        in_addr  = 5'd3;
        in_data  = 8'h77;
        drain_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready_a", in_ready, 0);
        chk("rst_we_a", we, 2'b00);
        tick();
        #1;
        chk("rst_in_ready_b", in_ready, 0);
        chk("rst_we_b", we, 2'b00);
        reset    = 1'b1;
        in_valid = 1'b0;
        drain_en = 1'b0;
        #1;
        chk("post_rst_count", count, 0);
        chk("post_rst_empty", empty, 1);
        chk("post_rst_full", full, 0);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_we", we, 2'b00);

        // Three pushes with the drain disabled
        in_valid = 1'b1;
        in_addr = 5'd1; in_data = 8'h11; tick();
        in_addr = 5'd2; in_data = 8'h22; tick();
        in_addr = 5'd3; in_data = 8'h33; tick();
        in_valid = 1'b0;
        #1;
        chk("p3_count", count, 3);
        chk("p3_waddress1", waddress1, 1);
        chk("p3_wdata1", wdata1, 8'h11);
        chk("p3_waddress2", waddress2, 2);
        chk("p3_wdata2", wdata2, 8'h22);
        chk("p3_we", we, 2'b00);

        // Dual drain, then a single drain, then empty
        drain_en = 1'b1;
        #1;
        chk("d2_we", we, 2'b11);
        tick();
        #1;
        chk("d1_count", count, 1);
        chk("d1_waddress1", waddress1, 3);
        chk("d1_wdata1", wdata1, 8'h33);
        chk("d1_we", we, 2'b01);
        tick();
        #1;
        chk("d0_empty", empty, 1);
        chk("d0_count", count, 0);
        chk("d0_we_empty", we, 2'b00);
        drain_en = 1'b0;

        // Fill to DEPTH, hold the ninth request, then free space
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_addr = 5'(i);
            in_data = 8'hA0 + 8'(i);
            tick();
        end
        in_addr = 5'd9;
        in_data = 8'h99;
        #1;
        chk("full_flag", full, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 8);
        tick();
        #1;
        chk("held_count", count, 8);
        chk("held_waddress1", waddress1, 0);
        chk("held_wdata1", wdata1, 8'hA0);
        chk("held_waddress2", waddress2, 1);
        drain_en = 1'b1;
        #1;
        chk("full_drain_in_ready", in_ready, 0);
        chk("full_drain_we", we, 2'b11);
        tick();
        drain_en = 1'b0;
        #1;
        chk("after_drain_count", count, 6);
        chk("after_drain_in_ready", in_ready, 1);
        chk("after_drain_wdata1", wdata1, 8'hA2);
        tick();
        in_valid = 1'b0;
        #1;
        chk("ninth_count", count, 7);
        drain_en = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("tail_count", count, 1);
        chk("tail_waddress1", waddress1, 9);
        chk("tail_wdata1", wdata1, 8'h99);
        tick();
        #1;
        chk("tail_empty", empty, 1);

        // Pointers now at 4. Push while draining from empty: no bypass.
        in_valid = 1'b1;
        in_addr = 5'd10; in_data = 8'h41;
        #1;
        chk("nobypass_we", we, 2'b00);
        tick();
        #1;
        chk("pd_head_addr_a", waddress1, 10);
        chk("pd_head_data_a", wdata1, 8'h41);
        in_addr = 5'd11; in_data = 8'h42;
        #1;
        chk("pd_we_a", we, 2'b01);
        tick();
        #1;
        chk("pd_count_b", count, 1);
        chk("pd_head_addr_b", waddress1, 11);
        chk("pd_head_data_b", wdata1, 8'h42);
        in_addr = 5'd12; in_data = 8'h43;
        tick();
        in_valid = 1'b0;
        #1;
        chk("pd_head_data_c", wdata1, 8'h43);
        tick();
        drain_en = 1'b0;
        #1;
        chk("pd_empty", empty, 1);

        // Same-address pair straddling index 7/0
        in_valid = 1'b1;
        in_addr = 5'd30; in_data = 8'h5A; tick();
        in_addr = 5'd30; in_data = 8'hC3; tick();
        in_valid = 1'b0;
        #1;
        chk("wrap_count", count, 2);
        chk("wrap_waddress1", waddress1, 30);
        chk("wrap_wdata1", wdata1, 8'h5A);
        chk("wrap_waddress2", waddress2, 30);
        chk("wrap_wdata2", wdata2, 8'hC3);
        drain_en = 1'b1;
        #1;
        chk("wrap_we", we, 2'b11);
        tick();
        drain_en = 1'b0;
        #1;
        chk("wrap_empty", empty, 1);

        // Reset with four entries buffered
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_addr = 5'd20 + 5'(i);
            in_data = 8'hD0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("pre_rst_count", count, 4);
        reset    = 1'b0;
        drain_en = 1'b1;
        #1;
        chk("mid_rst_we", we, 2'b00);
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        #1;
        chk("mid_rst_count", count, 0);
        reset = 1'b1;
        #1;
        chk("rel_empty", empty, 1);
        chk("rel_we", we, 2'b00);
        drain_en = 1'b0;
        in_valid = 1'b1;
        in_addr = 5'd5; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        drain_en = 1'b1;
        #1;
        chk("rel_count", count, 1);
        chk("rel_waddress1", waddress1, 5);
        chk("rel_wdata1", wdata1, 8'h55);
        chk("rel_we_one", we, 2'b01);
        tick();
        drain_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Write-side staging FIFO directly upstream of the dual-write-port register file.
- Accepts one register write request per cycle from the execute/write-back path via a valid/ready handshake and buffers it.
- Drains up to two requests per cycle onto the register file's two write ports (waddress1/wdata1, waddress2/wdata2, we[1:0]), gated by drain_en, which the consumer ties to its ce && en.
- Program order is preserved: older entry on port 1, newer on port 2. The register file gives port 2 priority on a same-address collision, so the newer write wins.

Parameters:
- DEPTH, 8, number of buffered write requests; power of two, >= 2.
- PTR_WIDTH, 3, log2(DEPTH).
- ADDR_WIDTH, 5, register address width; matches the register file.
- WIDTH, 8, data width; matches the register file.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; low at a rising edge clears the block.
- in_valid  input  1  write request present.
- in_ready  output  1  buffer can accept a request this cycle.
- in_addr  input  ADDR_WIDTH  destination register of request.
- in_data  input  WIDTH  data of request.
- drain_en  input  1  consumer will commit we[] this edge (its ce && en).
- waddress1  output  ADDR_WIDTH  address of oldest entry.
- wdata1  output  WIDTH  data of oldest entry.
- waddress2  output  ADDR_WIDTH  address of second-oldest entry.
- wdata2  output  WIDTH  data of second-oldest entry.
- we  output  2  per-port write enables to register file.
- count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular buffer of DEPTH {addr,data} entries; rd_ptr, wr_ptr (PTR_WIDTH bits, natural wrap), count (PTR_WIDTH+1 bits).
- Reset (reset==0 at edge): rd_ptr=0, wr_ptr=0, count=0. Entry contents are not cleared.
- Reset outputs: in_ready=0 and we=2'b00 while reset is low (combinational override). After reset: count=0, empty=1, full=0, in_ready=1, we=00.
- Push: push = in_valid && in_ready. in_ready = !full, computed from registered count only (no same-cycle pass-through of a drain). On push, entry[wr_ptr] <= {in_addr,in_data} and wr_ptr++.
- Port outputs are combinational from buffer state:
  - waddress1/wdata1 = entry[rd_ptr]; waddress2/wdata2 = entry[rd_ptr+1] (mod DEPTH).
  - we[0] = drain_en && count>=1; we[1] = drain_en && count>=2.
  - Address/data are don't-care when the corresponding we bit is 0.
- Pop: pops = we[0] + we[1], i.e. 0, 1 or 2. At the edge rd_ptr += pops and count <= count + push - pops.
- Latency: a request pushed at edge N is first visible on port 1 (or port 2) after edge N; it can drain at edge N+1. The buffer never bypasses the input straight to the write ports.
- Ordering: port 1 always carries the older entry. Same-address pairs are issued together; the register file's port-2 priority gives program order.
- Full: in_ready=0, so in_valid is ignored (the request holds upstream). No push occurs even if drain_en frees space that cycle; in_ready returns to 1 the cycle after the drain.
- Empty: we=00 regardless of drain_en; pointers unchanged.
- Simultaneous push and drain: both take effect; count changes by +1-pops. With count==1, push and drain_en: entry 0 drains and the new entry becomes the head; count stays 1.
- Wrap-around: pointers wrap modulo DEPTH. A pair straddling index DEPTH-1/0 drains correctly.
- Reset mid-operation: buffered entries are discarded. A request offered during the reset cycle is not accepted.
- drain_en low: buffer holds; fills to DEPTH, then stalls.

Test Plan:
- Reset low for 2 cycles with in_valid=1, addr=3 -> in_ready=0, we=00 during reset; after release count=0, empty=1, in_ready=1.
- drain_en=0; push (1,0x11),(2,0x22),(3,0x33) -> count=3; waddress1=1/wdata1=0x11, waddress2=2/wdata2=0x22; we=00.
- Same state, drain_en=1 for one cycle -> we=11 that cycle; next cycle count=1, waddress1=3, wdata1=0x33, we=01 while drain_en stays 1; then empty=1.
- drain_en=0; push 8 entries (addr 0..7, data 0xA0..0xA7) -> full=1, in_ready=0; 9th request (addr 9) held, not stored. drain_en=1 one cycle -> count=6, in_ready=1 next cycle, addr 9 accepted.
- Wrap: cycle 5 pushes/5 drains, then push (30,0x5A),(30,0xC3) and drain -> same cycle we=11, waddress1=waddress2=30, wdata2=0xC3 (newer on port 2).
- count=4, then reset low one edge -> count=0, we=00; earlier entries never appear on the write ports after release.
